mpf_svc_vtp_pt_sw_ooo: RTL and testbench
========================================

# mpf_svc_vtp_pt_sw_ooo

Software-assisted VTP page-translation service with out-of-order completion. It sits between the VTP TLB miss path (pt_walk server side) and the host write channel plus VTP CSRs. Untranslated VAs are posted to a host ring buffer, and host software answers through a CSR. Up to N_SLOTS requests may be outstanding. Each request carries a slot index so software may answer in any order. Requests with no answer are re-posted after a timeout.

## Interface
- N_SLOTS, 8: outstanding-request slots; power of 2, 2..64.
- RING_ENTRIES, 64: lines in the 4KB request ring; power of 2, ≥ N_SLOTS, ≤ 64.
- VA_IDX_BITS, 36: 4KB VA page-index width.
- PA_IDX_BITS, 36: 4KB PA page-index width.
- META_BITS, 2 / TAG_BITS, 4: opaque request metadata and tag widths.
- TIMEOUT_CYCLES, 16384: retry period; multiple of 4; 0 disables retry.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_en  in  1  new walk request; legal only while req_rdy.
- req_rdy  out  1  request accepted this cycle if req_en.
- req_va  in  VA_IDX_BITS  VA page index.
- req_meta  in  META_BITS  metadata.
- req_spec  in  1  speculative flag.
- req_tag  in  TAG_BITS  tag.
- buf_pa_valid  in  1  one-cycle pulse loading the ring line address.
- buf_pa  in  58  ring base line address (page-aligned).
- write_rdy  in  1  host write channel can accept.
- write_en  out  1  host write.
- write_addr  out  58  line address.
- write_data  out  64  request word.
- csr_rsp_valid  in  1  software response pulse.
- csr_rsp  in  64  response word.
- rsp_en  out  1  translation complete.
- rsp_va, rsp_pa, rsp_meta, rsp_spec, rsp_tag  out  as req  returned fields.
- rsp_big_page, rsp_not_present  out  1  page size 2MB; translation failed.
- ev_busy, ev_failed, ev_retry, ev_stale  out  1  event level (busy) and event pulses.

## Operation
- Slot state: busy bit, VA, meta, spec, tag, 2-bit age per slot. Allocation takes the lowest-index free slot.
- Input register: captures a request on req_en. `req_rdy = ~in_valid & free_slot_exists & initialized`. initialized is set by the first buf_pa_valid.
- Send: a pending input or retry is issued when write_rdy is high. Retry has priority over new requests. On send, the slot is marked busy and the ring index increments modulo RING_ENTRIES.
- Request word: `{va, 12'b0}` with [11:4] = slot index (zero-extended), [3:2] = 0, [1] = spec, [0] = 1.
- write_addr: buf_pa with low log2(RING_ENTRIES) bits replaced by the ring index.
- Response word: [PA_IDX_BITS+11:12] = PA index, [11:4] = slot, [1] = big page, [0] = not present.
- If the addressed slot is busy: emit rsp_* from that slot's stored fields, free the slot, pulse ev_failed when bit0 is set.
- If the slot is not busy, or its index is ≥ N_SLOTS: drop the response and pulse ev_stale.
- Retry: a tick fires every TIMEOUT_CYCLES/4 cycles. On each tick, every busy slot's age increments, saturating at 3. A slot at age 3 on a tick is queued for retry; the lowest pending slot is served first. Retry re-sends the identical word to a new ring index, clears the age, and pulses ev_retry.
- A response for a slot with a pending retry cancels the retry.
- buf_pa_valid: loads buf_pa and zeroes the ring index. Busy slots are untouched.

## Timing
- Reset values: all outputs 0, req_rdy 0, slots free, ring index 0, initialized 0.
- req_en at cycle t: write_en at t+2 at the earliest. req_rdy drops at t+1.
- csr_rsp_valid at t: rsp_en at t+2. The slot becomes free for allocation at t+3.
- Simultaneous response and retry selection of the same slot: the response wins and no write is issued.
- Simultaneous allocation and free: the freed slot is not reusable in that cycle.
- All slots busy: req_rdy stays 0 and the input register holds its request.
- Ring index wraps from RING_ENTRIES-1 to 0.
- Reset asserted mid-operation: in-flight state is discarded asynchronously. No rsp_en is produced for lost requests.
- ev_busy: registered OR of the slot busy bits.

## Test plan
- Init buf_pa = 0x1000, then issue 2 requests (VA 0xA, 0xB). Expect writes to 0x1000 and 0x1001 with data `{0xA,12'h001}` and `{0xB,12'h011}`.
- Respond to slot 1 before slot 0 (PA 0x55, then 0x44). Expect rsp_en twice, in that order, with VA/tag matched per slot.
- Fill all 8 slots. Expect req_rdy = 0. Respond to slot 3. Expect the next request to land in slot 3 and req_rdy to recover.
- Set TIMEOUT_CYCLES = 16 and leave a request unanswered. Expect a retry write with the same data at ring index +1 and an ev_retry pulse.
- Send a response for a free slot, then for slot 9 with N_SLOTS = 8. Expect ev_stale each time and no rsp_en.
- Respond with bit0 set. Expect rsp_not_present = 1 and ev_failed pulsed once. Assert reset mid-burst and expect all outputs 0 immediately.

Source files
------------

// File: rtl/mpf_svc_vtp_pt_sw_ooo.sv
// Software-assisted VTP page walker: posts miss VAs to a host ring, accepts
// out-of-order CSR answers per slot, and re-posts unanswered requests on timeout.
module mpf_svc_vtp_pt_sw_ooo #(
    parameter int unsigned N_SLOTS        = 8,
    parameter int unsigned RING_ENTRIES   = 64,
    parameter int unsigned VA_IDX_BITS    = 36,
    parameter int unsigned PA_IDX_BITS    = 36,
    parameter int unsigned META_BITS      = 2,
    parameter int unsigned TAG_BITS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16384
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_en,
    output logic                   req_rdy,
    input  logic [VA_IDX_BITS-1:0] req_va,
    input  logic [META_BITS-1:0]   req_meta,
    input  logic                   req_spec,
    input  logic [TAG_BITS-1:0]    req_tag,
    input  logic                   buf_pa_valid,
    input  logic [57:0]            buf_pa,
    input  logic                   write_rdy,
    output logic                   write_en,
    output logic [57:0]            write_addr,
    output logic [63:0]            write_data,
    input  logic                   csr_rsp_valid,
    input  logic [63:0]            csr_rsp,
    output logic                   rsp_en,
    output logic [VA_IDX_BITS-1:0] rsp_va,
    output logic [PA_IDX_BITS-1:0] rsp_pa,
    output logic [META_BITS-1:0]   rsp_meta,
    output logic                   rsp_spec,
    output logic [TAG_BITS-1:0]    rsp_tag,
    output logic                   rsp_big_page,
    output logic                   rsp_not_present,
    output logic                   ev_busy,
    output logic                   ev_failed,
    output logic                   ev_retry,
    output logic                   ev_stale
);
    localparam int unsigned SLOT_BITS   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int unsigned RING_BITS   = $clog2(RING_ENTRIES);
    localparam int unsigned TICK_PERIOD = TIMEOUT_CYCLES / 4;
    localparam int unsigned TICK_BITS   = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int unsigned TICK_LAST   = (TICK_PERIOD > 0) ? TICK_PERIOD - 1 : 0;

    logic                   initialized_q;
    logic [57:0]            buf_pa_q;
    logic [RING_BITS-1:0]   ring_idx_q;
    logic [TICK_BITS-1:0]   tick_cnt_q;

    logic                   in_valid_q;
    logic [VA_IDX_BITS-1:0] in_va_q;
    logic [META_BITS-1:0]   in_meta_q;
    logic                   in_spec_q;
    logic [TAG_BITS-1:0]    in_tag_q;

    logic [N_SLOTS-1:0]     busy_q;
    logic [N_SLOTS-1:0]     retry_q;
    logic [1:0]             age_q      [N_SLOTS];
    logic [VA_IDX_BITS-1:0] slot_va_q  [N_SLOTS];
    logic [META_BITS-1:0]   slot_meta_q[N_SLOTS];
    logic                   slot_spec_q[N_SLOTS];
    logic [TAG_BITS-1:0]    slot_tag_q [N_SLOTS];

    logic                   rsp_valid_q;
    logic [63:0]            rsp_word_q;

    logic                   free_exists, retry_any, rsp_hit, tick;
    logic                   do_new, do_retry, send, send_spec;
    logic [SLOT_BITS-1:0]   free_slot, retry_idx, rsp_idx, send_idx;
    logic [7:0]             rsp_slot;
    logic [N_SLOTS-1:0]     rsp_mask, retry_cand;
    logic [VA_IDX_BITS-1:0] send_va;
    logic [63:0]            send_word;

    assign req_rdy = ~in_valid_q & free_exists & initialized_q;
    assign tick    = (TICK_PERIOD != 0) && (tick_cnt_q == TICK_BITS'(TICK_LAST));

    always_comb begin
        free_exists = 1'b0;
        free_slot   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_exists = 1'b1;
                free_slot   = SLOT_BITS'(i);
            end
        end

        rsp_slot = rsp_word_q[11:4];
        rsp_idx  = rsp_slot[SLOT_BITS-1:0];
        rsp_hit  = rsp_valid_q && (32'(rsp_slot) < N_SLOTS) && busy_q[rsp_idx];
        rsp_mask = '0;
        if (rsp_hit) rsp_mask[rsp_idx] = 1'b1;

        // A response arriving for a slot awaiting retry beats the retry.
        retry_cand = retry_q & busy_q & ~rsp_mask;
        retry_any  = 1'b0;
        retry_idx  = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (retry_cand[i]) begin
                retry_any = 1'b1;
                retry_idx = SLOT_BITS'(i);
            end
        end

        do_retry  = retry_any && write_rdy;
        do_new    = in_valid_q && free_exists && write_rdy && !retry_any;
        send      = do_retry || do_new;
        send_idx  = do_retry ? retry_idx : free_slot;
        send_va   = do_retry ? slot_va_q[retry_idx] : in_va_q;
        send_spec = do_retry ? slot_spec_q[retry_idx] : in_spec_q;

        send_word                      = '0;
        send_word[VA_IDX_BITS+11:12]   = send_va;
        send_word[11:4]                = 8'(send_idx);
        send_word[1]                   = send_spec;
        send_word[0]                   = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            initialized_q   <= 1'b0;
            buf_pa_q        <= '0;
            ring_idx_q      <= '0;
            tick_cnt_q      <= '0;
            in_valid_q      <= 1'b0;
            in_va_q         <= '0;
            in_meta_q       <= '0;
            in_spec_q       <= 1'b0;
            in_tag_q        <= '0;
            busy_q          <= '0;
            retry_q         <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_word_q      <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                age_q[i]       <= '0;
                slot_va_q[i]   <= '0;
                slot_meta_q[i] <= '0;
                slot_spec_q[i] <= 1'b0;
                slot_tag_q[i]  <= '0;
            end
            write_en        <= 1'b0;
            write_addr      <= '0;
            write_data      <= '0;
            rsp_en          <= 1'b0;
            rsp_va          <= '0;
            rsp_pa          <= '0;
            rsp_meta        <= '0;
            rsp_spec        <= 1'b0;
            rsp_tag         <= '0;
            rsp_big_page    <= 1'b0;
            rsp_not_present <= 1'b0;
            ev_busy         <= 1'b0;
            ev_failed       <= 1'b0;
            ev_retry        <= 1'b0;
            ev_stale        <= 1'b0;
        end else begin
            if (buf_pa_valid) begin
                initialized_q <= 1'b1;
                buf_pa_q      <= buf_pa;
                ring_idx_q    <= '0;
            end else if (send) begin
                ring_idx_q <= ring_idx_q + 1'b1;
            end
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;

            if (req_en && req_rdy) begin
                in_valid_q <= 1'b1;
                in_va_q    <= req_va;
                in_meta_q  <= req_meta;
                in_spec_q  <= req_spec;
                in_tag_q   <= req_tag;
            end else if (do_new) begin
                in_valid_q <= 1'b0;
            end

            rsp_valid_q <= csr_rsp_valid;
            if (csr_rsp_valid) rsp_word_q <= csr_rsp;

            // Later assignments win: free beats retry bookkeeping, which beats aging.
            for (int i = 0; i < N_SLOTS; i++) begin
                if (tick && busy_q[i]) begin
                    if (age_q[i] == 2'd3) retry_q[i] <= 1'b1;
                    else                  age_q[i]   <= age_q[i] + 2'd1;
                end
                if (do_retry && retry_idx == SLOT_BITS'(i)) begin
                    age_q[i]   <= '0;
                    retry_q[i] <= 1'b0;
                end
                if (rsp_hit && rsp_idx == SLOT_BITS'(i)) begin
                    busy_q[i]  <= 1'b0;
                    retry_q[i] <= 1'b0;
                    age_q[i]   <= '0;
                end
                if (do_new && free_slot == SLOT_BITS'(i)) begin
                    busy_q[i]      <= 1'b1;
                    retry_q[i]     <= 1'b0;
                    age_q[i]       <= '0;
                    slot_va_q[i]   <= in_va_q;
                    slot_meta_q[i] <= in_meta_q;
                    slot_spec_q[i] <= in_spec_q;
                    slot_tag_q[i]  <= in_tag_q;
                end
            end

            write_en <= send;
            if (send) begin
                write_addr <= {buf_pa_q[57:RING_BITS], ring_idx_q};
                write_data <= send_word;
            end

            rsp_en <= rsp_hit;
            if (rsp_hit) begin
                rsp_va          <= slot_va_q[rsp_idx];
                rsp_meta        <= slot_meta_q[rsp_idx];
                rsp_spec        <= slot_spec_q[rsp_idx];
                rsp_tag         <= slot_tag_q[rsp_idx];
                rsp_pa          <= rsp_word_q[PA_IDX_BITS+11:12];
                rsp_big_page    <= rsp_word_q[1];
                rsp_not_present <= rsp_word_q[0];
            end

            ev_busy   <= |busy_q;
            ev_failed <= rsp_hit && rsp_word_q[0];
            ev_retry  <= do_retry;
            ev_stale  <= rsp_valid_q && !rsp_hit;
        end
    end
endmodule

// File: tb/tb_mpf_svc_vtp_pt_sw_ooo.sv
// Directed bench: instance a uses the default timeout, instance b a 16-cycle
// timeout to exercise the retry path.
module tb_mpf_svc_vtp_pt_sw_ooo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_req_en = 0, a_req_spec = 0, a_buf_pa_valid = 0, a_write_rdy = 1;
    logic [35:0] a_req_va = 0;
    logic [1:0]  a_req_meta = 0;
    logic [3:0]  a_req_tag = 0;
    logic [57:0] a_buf_pa = 0;
    logic        a_csr_rsp_valid = 0;
    logic [63:0] a_csr_rsp = 0;
    logic        a_req_rdy, a_write_en, a_rsp_en, a_rsp_spec, a_rsp_big_page, a_rsp_not_present;
    logic        a_ev_busy, a_ev_failed, a_ev_retry, a_ev_stale;
    logic [57:0] a_write_addr;
    logic [63:0] a_write_data;
    logic [35:0] a_rsp_va, a_rsp_pa;
    logic [1:0]  a_rsp_meta;
    logic [3:0]  a_rsp_tag;

    logic        b_req_en = 0, b_req_spec = 0, b_buf_pa_valid = 0, b_write_rdy = 1;
    logic [35:0] b_req_va = 0;
    logic [1:0]  b_req_meta = 0;
    logic [3:0]  b_req_tag = 0;
    logic [57:0] b_buf_pa = 0;
    logic        b_csr_rsp_valid = 0;
    logic [63:0] b_csr_rsp = 0;
    logic        b_req_rdy, b_write_en, b_rsp_en, b_rsp_spec, b_rsp_big_page, b_rsp_not_present;
    logic        b_ev_busy, b_ev_failed, b_ev_retry, b_ev_stale;
    logic [57:0] b_write_addr;
    logic [63:0] b_write_data;
    logic [35:0] b_rsp_va, b_rsp_pa;
    logic [1:0]  b_rsp_meta;
    logic [3:0]  b_rsp_tag;

    mpf_svc_vtp_pt_sw_ooo u_dut_a (
        .clk(clk), .reset(reset), .req_en(a_req_en), .req_rdy(a_req_rdy), .req_va(a_req_va),
        .req_meta(a_req_meta), .req_spec(a_req_spec), .req_tag(a_req_tag),
        .buf_pa_valid(a_buf_pa_valid), .buf_pa(a_buf_pa), .write_rdy(a_write_rdy),
        .write_en(a_write_en), .write_addr(a_write_addr), .write_data(a_write_data),
        .csr_rsp_valid(a_csr_rsp_valid), .csr_rsp(a_csr_rsp), .rsp_en(a_rsp_en),
        .rsp_va(a_rsp_va), .rsp_pa(a_rsp_pa), .rsp_meta(a_rsp_meta), .rsp_spec(a_rsp_spec),
        .rsp_tag(a_rsp_tag), .rsp_big_page(a_rsp_big_page), .rsp_not_present(a_rsp_not_present),
        .ev_busy(a_ev_busy), .ev_failed(a_ev_failed), .ev_retry(a_ev_retry),
        .ev_stale(a_ev_stale)
    );

    mpf_svc_vtp_pt_sw_ooo #(.TIMEOUT_CYCLES(16)) u_dut_b (
        .clk(clk), .reset(reset), .req_en(b_req_en), .req_rdy(b_req_rdy), .req_va(b_req_va),
        .req_meta(b_req_meta), .req_spec(b_req_spec), .req_tag(b_req_tag),
        .buf_pa_valid(b_buf_pa_valid), .buf_pa(b_buf_pa), .write_rdy(b_write_rdy),
        .write_en(b_write_en), .write_addr(b_write_addr), .write_data(b_write_data),
        .csr_rsp_valid(b_csr_rsp_valid), .csr_rsp(b_csr_rsp), .rsp_en(b_rsp_en),
        .rsp_va(b_rsp_va), .rsp_pa(b_rsp_pa), .rsp_meta(b_rsp_meta), .rsp_spec(b_rsp_spec),
        .rsp_tag(b_rsp_tag), .rsp_big_page(b_rsp_big_page), .rsp_not_present(b_rsp_not_present),
        .ev_busy(b_ev_busy), .ev_failed(b_ev_failed), .ev_retry(b_ev_retry),
        .ev_stale(b_ev_stale)
    );

    // Event logs, sampled on the falling edge.
    logic [57:0] aw_addr[$];
    logic [63:0] aw_data[$];
    logic [35:0] ar_va[$];
    logic [35:0] ar_pa[$];
    logic [3:0]  ar_tag[$];
    logic        ar_np[$];
    int          a_stale_n = 0, a_failed_n = 0;
    logic [57:0] bw_addr[$];
    logic [63:0] bw_data[$];
    int          b_retry_n = 0, b_rsp_n = 0;
    logic [35:0] b_last_pa = 0;
    logic [3:0]  b_last_tag = 0;
    logic        b_last_spec = 0;

    always @(negedge clk) begin
        if (a_write_en) begin
            aw_addr.push_back(a_write_addr);
            aw_data.push_back(a_write_data);
        end
        if (a_rsp_en) begin
            ar_va.push_back(a_rsp_va);
            ar_pa.push_back(a_rsp_pa);
            ar_tag.push_back(a_rsp_tag);
            ar_np.push_back(a_rsp_not_present);
        end
        if (a_ev_stale) a_stale_n++;
        if (a_ev_failed) a_failed_n++;
        if (b_write_en) begin
            bw_addr.push_back(b_write_addr);
            bw_data.push_back(b_write_data);
        end
        if (b_ev_retry) b_retry_n++;
        if (b_rsp_en) begin
            b_rsp_n++;
            b_last_pa   = b_rsp_pa;
            b_last_tag  = b_rsp_tag;
            b_last_spec = b_rsp_spec;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic a_req(input logic [35:0] va, input logic [3:0] tag);
        for (int i = 0; i < 60 && a_req_rdy !== 1'b1; i++) step(1);
        chk("a_req_rdy_wait", 64'(a_req_rdy), 64'd1);
        a_req_va  = va;
        a_req_tag = tag;
        a_req_en  = 1'b1;
        step(1);
        a_req_en  = 1'b0;
    endtask

    task automatic a_rsp(input logic [63:0] word);
        a_csr_rsp       = word;
        a_csr_rsp_valid = 1'b1;
        step(1);
        a_csr_rsp_valid = 1'b0;
    endtask

    task automatic b_rsp(input logic [63:0] word);
        b_csr_rsp       = word;
        b_csr_rsp_valid = 1'b1;
        step(1);
        b_csr_rsp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int st0;
        step(3);
        chk("reset_req_rdy", 64'(a_req_rdy), 64'd0);
        chk("reset_write_en", 64'(a_write_en), 64'd0);
        chk("reset_ev_busy", 64'(a_ev_busy), 64'd0);
        reset = 1'b0;
        step(2);
        chk("uninit_req_rdy", 64'(a_req_rdy), 64'd0);

        a_buf_pa = 58'h1000;
        a_buf_pa_valid = 1'b1;
        step(1);
        a_buf_pa_valid = 1'b0;
        chk("init_req_rdy", 64'(a_req_rdy), 64'd1);

        // Two requests; first one checked cycle by cycle.
        a_req(36'hA, 4'h1);
        chk("req_rdy_drop", 64'(a_req_rdy), 64'd0);
        chk("write_not_t1", 64'(a_write_en), 64'd0);
        step(1);
        chk("write_en_t2", 64'(a_write_en), 64'd1);
        chk("write_addr0", 64'(a_write_addr), 64'h1000);
        chk("write_data0", a_write_data, 64'hA001);
        a_req(36'hB, 4'h2);
        step(3);
        chk("write_cnt2", 64'(aw_addr.size()), 64'd2);
        chk("write_addr1", 64'(aw_addr[1]), 64'h1001);
        chk("write_data1", aw_data[1], 64'hB011);

        // Out-of-order answers.
        a_rsp(64'h55010);
        chk("rsp_en_t1", 64'(a_rsp_en), 64'd0);
        step(1);
        chk("rsp_en_t2", 64'(a_rsp_en), 64'd1);
        chk("rsp0_va", 64'(a_rsp_va), 64'hB);
        chk("rsp0_pa", 64'(a_rsp_pa), 64'h55);
        chk("rsp0_tag", 64'(a_rsp_tag), 64'h2);
        a_rsp(64'h44000);
        step(2);
        chk("rsp_cnt2", 64'(ar_va.size()), 64'd2);
        chk("rsp1_va", 64'(ar_va[1]), 64'hA);
        chk("rsp1_pa", 64'(ar_pa[1]), 64'h44);
        chk("rsp1_tag", 64'(ar_tag[1]), 64'h1);

        // Fill all slots.
        aw_addr.delete(); aw_data.delete();
        ar_va.delete(); ar_pa.delete(); ar_tag.delete(); ar_np.delete();
        for (int i = 0; i < 8; i++) a_req(36'h100 + 36'(i), 4'(i));
        step(4);
        chk("full_req_rdy", 64'(a_req_rdy), 64'd0);
        chk("full_ev_busy", 64'(a_ev_busy), 64'd1);
        chk("fill_cnt", 64'(aw_addr.size()), 64'd8);
        chk("fill7_addr", 64'(aw_addr[7]), 64'h1009);
        chk("fill7_data", aw_data[7], 64'h107071);
        step(5);
        chk("full_req_rdy_hold", 64'(a_req_rdy), 64'd0);
        a_rsp(64'h33030);
        a_req(36'h200, 4'h9);
        step(3);
        chk("reuse_cnt", 64'(aw_addr.size()), 64'd9);
        chk("reuse_addr", 64'(aw_addr[8]), 64'h100A);
        chk("reuse_data", aw_data[8], 64'h200031);
        chk("slot3_rsp_va", 64'(ar_va[0]), 64'h103);
        chk("slot3_rsp_tag", 64'(ar_tag[0]), 64'h3);
        chk("slot3_rsp_pa", 64'(ar_pa[0]), 64'h33);

        // Not-present answer, then stale answers.
        ar_va.delete(); ar_pa.delete(); ar_tag.delete(); ar_np.delete();
        st0 = a_stale_n;
        a_rsp(64'h1);
        step(3);
        chk("np_rsp_cnt", 64'(ar_va.size()), 64'd1);
        chk("np_flag", 64'(ar_np[0]), 64'd1);
        chk("np_va", 64'(ar_va[0]), 64'h100);
        chk("failed_cnt", 64'(a_failed_n), 64'd1);
        a_rsp(64'h0);
        step(3);
        a_rsp(64'h90);
        step(3);
        chk("stale_cnt", 64'(a_stale_n - st0), 64'd2);
        chk("stale_no_rsp", 64'(ar_va.size()), 64'd1);
        chk("failed_once", 64'(a_failed_n), 64'd1);

        // Reset in the middle of activity.
        a_req(36'h300, 4'hC);
        for (int i = 0; i < 10 && a_write_en !== 1'b1; i++) step(1);
        chk("pre_reset_write", 64'(a_write_en), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_write_en", 64'(a_write_en), 64'd0);
        chk("rst_ev_busy", 64'(a_ev_busy), 64'd0);
        chk("rst_req_rdy", 64'(a_req_rdy), 64'd0);
        chk("rst_rsp_en", 64'(a_rsp_en), 64'd0);
        step(2);
        reset = 1'b0;
        step(1);
        st0 = a_stale_n;
        a_rsp(64'h10);
        step(3);
        chk("post_rst_stale", 64'(a_stale_n - st0), 64'd1);
        chk("post_rst_no_rsp", 64'(ar_va.size()), 64'd1);

        // Retry path on the short-timeout instance.
        b_buf_pa = 58'h2000;
        b_buf_pa_valid = 1'b1;
        step(1);
        b_buf_pa_valid = 1'b0;
        for (int i = 0; i < 10 && b_req_rdy !== 1'b1; i++) step(1);
        chk("b_req_rdy", 64'(b_req_rdy), 64'd1);
        b_req_va = 36'h7; b_req_tag = 4'h5; b_req_spec = 1'b1; b_req_en = 1'b1;
        step(1);
        b_req_en = 1'b0;
        step(3);
        chk("b_write_cnt1", 64'(bw_addr.size()), 64'd1);
        chk("b_write_addr0", 64'(bw_addr[0]), 64'h2000);
        chk("b_write_data0", bw_data[0], 64'h7003);
        for (int i = 0; i < 100 && bw_addr.size() < 2; i++) step(1);
        chk("b_retry_write", 64'(bw_addr.size()), 64'd2);
        chk("b_retry_addr", 64'(bw_addr[1]), 64'h2001);
        chk("b_retry_data", bw_data[1], 64'h7003);
        step(1);
        chk("b_ev_retry_cnt", 64'(b_retry_n), 64'd1);
        b_rsp(64'h99000);
        step(3);
        chk("b_rsp_cnt", 64'(b_rsp_n), 64'd1);
        chk("b_rsp_pa", 64'(b_last_pa), 64'h99);
        chk("b_rsp_tag", 64'(b_last_tag), 64'h5);
        chk("b_rsp_spec", 64'(b_last_spec), 64'd1);
        step(40);
        chk("b_no_more_retry", 64'(bw_addr.size()), 64'd2);
        chk("b_retry_once", 64'(b_retry_n), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
